// File: rtl/rle_pkg.sv
// Shared types for the run-length codec: token layout, encoder/decoder FSM states.
// No logic; latency and backpressure are properties of the modules that import it.
// Token bit SIZE selects literal (0) or run header (1).
package rle_pkg;

    localparam int SIZE     = 7;
    localparam int LIMIT    = 255;
    localparam int TOK_W    = SIZE + 1;
    localparam int KIND_BIT = SIZE;

    typedef struct packed {
        logic [SIZE:0] data;
        logic          valid;
    } out_st;

    typedef enum logic [1:0] {
        FETCH,
        WAIT_CNT,
        EMIT
    } dec_state_e;

    typedef enum logic [1:0] {
        ENC_IDLE,
        ENC_COUNT,
        ENC_FLUSH
    } enc_state_e;

    function automatic logic is_header(input logic [SIZE:0] tok);
        return tok[KIND_BIT];
    endfunction

endpackage

// File: rtl/rle_token_fifo.sv
// Synchronous token FIFO, DEPTH x WIDTH, async active-low reset.
// Latency: a word written in cycle t is visible on rdata in cycle t+1.
// Backpressure: caller must not push when full unless it pops in the same cycle.
module rle_token_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Extra pointer bit distinguishes full from empty when indices match.
    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/rle_decoder.sv
// Run-length decoder: expands literal / header+count tokens back into a symbol stream.
// Latency: 2 cycles token-in to symbol-out when idle; 1 symbol/cycle sustained.
// Backpressure: sym_ready=0 holds sym_out; FIFO absorbs input, overflow drops and sticks.
module rle_decoder
    import rle_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  out_st                    dataIn,
    output logic [SIZE-1:0]          sym_out,
    output logic                     sym_valid,
    input  logic                     sym_ready,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    dec_state_e       state_q, state_d;
    logic [SIZE-1:0]  sym_q, sym_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             overflow_q;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [SIZE:0]    head;

    assign fifo_push = dataIn.valid && (!fifo_full || fifo_pop);

    rle_token_fifo #(
        .WIDTH (TOK_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (dataIn.data),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FETCH;
            sym_q      <= '0;
            rem_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sym_q      <= sym_d;
            rem_q      <= rem_d;
            overflow_q <= overflow_q | (dataIn.valid & ~fifo_push);
        end
    end

    always_comb begin
        state_d  = state_q;
        sym_d    = sym_q;
        rem_d    = rem_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sym_d    = head[SIZE-1:0];
                    if (is_header(head)) begin
                        state_d = WAIT_CNT;
                    end else begin
                        rem_d   = '0;
                        state_d = EMIT;
                    end
                end
            end
            WAIT_CNT: begin
                // Whatever follows a header is its count, even if bit SIZE is set.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    rem_d    = head[CNT_W-1:0];
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (sym_ready) begin
                    if (rem_q != '0) begin
                        rem_d = rem_q - CNT_W'(1);
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sym_d    = head[SIZE-1:0];
                        if (is_header(head)) begin
                            state_d = WAIT_CNT;
                        end else begin
                            rem_d = '0;
                        end
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        sym_valid = (state_q == EMIT);
        sym_out   = (state_q == EMIT) ? sym_q : '0;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_rle_decoder.sv
// Directed bench for rle_decoder: literals, runs, overflow, backpressure, split header, reset.
module tb_rle_decoder;
    import rle_pkg::*;

    logic        clock;
    logic        reset_n;
    out_st       dataIn;
    logic [6:0]  sym_out;
    logic        sym_valid;
    logic        sym_ready;
    logic        overflow;
    logic [4:0]  fifo_level;

    int          total;
    int          bad;
    int          cyc_n;
    logic [6:0]  got_sym [$];
    int          got_cyc [$];

    rle_decoder #(.DEPTH(16), .CNT_W(8)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .dataIn     (dataIn),
        .sym_out    (sym_out),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply one cycle of inputs at the falling edge and log the beat that the next rising edge accepts.
    task automatic drive(input logic v, input logic [7:0] d, input logic rdy);
        @(negedge clock);
        dataIn.valid = v;
        dataIn.data  = d;
        sym_ready    = rdy;
        if (sym_valid && sym_ready) begin
            got_sym.push_back(sym_out);
            got_cyc.push_back(cyc_n);
        end
        cyc_n++;
    endtask

    task automatic clear_log();
        got_sym.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        dataIn  = '0;
        sym_ready = 1'b0;
        #2;
        total++;
        if (sym_valid !== 1'b0 || sym_out !== 7'h00) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b sym=%h, want 0/00", sym_valid, sym_out);
        end
        total++;
        if (overflow !== 1'b0 || fifo_level !== 5'd0) begin
            bad++;
            $display("FAIL reset_status: got ovf=%b lvl=%0d, want 0/0", overflow, fifo_level);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) drive(1'b0, 8'h00, 1'b1);
        total++;
        if (sym_valid !== 1'b0 || fifo_level !== 5'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got valid=%b lvl=%0d, want 0/0", sym_valid, fifo_level);
        end
    endtask

    task automatic test_literals();
        logic [6:0] exp [3];
        int start;
        exp = '{7'h05, 7'h12, 7'h33};
        clear_log();
        start = cyc_n;
        drive(1'b1, 8'h05, 1'b1);
        drive(1'b1, 8'h12, 1'b1);
        drive(1'b1, 8'h33, 1'b1);
        repeat (6) drive(1'b0, 8'h00, 1'b1);
        total++;
        if (got_sym.size() != 3) begin
            bad++;
            $display("FAIL literal_count: got %0d beats, want 3", got_sym.size());
        end
        for (int i = 0; i < 3 && i < got_sym.size(); i++) begin
            total++;
            if (got_sym[i] !== exp[i] || got_cyc[i] != start + 2 + i) begin
                bad++;
                $display("FAIL literal_beat%0d: got sym=%h cyc=%0d, want sym=%h cyc=%0d",
                         i, got_sym[i], got_cyc[i] - start, exp[i], 2 + i);
            end
        end
    endtask

    task automatic test_short_run();
        clear_log();
        drive(1'b1, 8'h8A, 1'b1);
        drive(1'b1, 8'h03, 1'b1);
        repeat (10) drive(1'b0, 8'h00, 1'b1);
        total++;
        if (got_sym.size() != 4) begin
            bad++;
            $display("FAIL run3_count: got %0d beats, want 4", got_sym.size());
        end
        for (int i = 0; i < got_sym.size(); i++) begin
            total++;
            if (got_sym[i] !== 7'h0A || got_cyc[i] != got_cyc[0] + i) begin
                bad++;
                $display("FAIL run3_beat%0d: got sym=%h off=%0d, want sym=0a off=%0d",
                         i, got_sym[i], got_cyc[i] - got_cyc[0], i);
            end
        end
        clear_log();
        drive(1'b1, 8'h8A, 1'b1);
        drive(1'b1, 8'h00, 1'b1);
        repeat (8) drive(1'b0, 8'h00, 1'b1);
        total++;
        if (got_sym.size() != 1 || got_sym[0] !== 7'h0A) begin
            bad++;
            $display("FAIL run0: got %0d beats, want exactly 1 beat of 0a", got_sym.size());
        end
    endtask

    task automatic test_max_run();
        int n7f;
        int nlit;
        int gaps;
        clear_log();
        drive(1'b1, 8'hFF, 1'b1);
        drive(1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, 8'(i + 1), 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        total++;
        if (overflow !== 1'b1 || fifo_level !== 5'd16) begin
            bad++;
            $display("FAIL overflow_full: got ovf=%b lvl=%0d, want 1/16", overflow, fifo_level);
        end
        repeat (300) drive(1'b0, 8'h00, 1'b1);
        total++;
        if (got_sym.size() != 272) begin
            bad++;
            $display("FAIL maxrun_count: got %0d beats, want 272", got_sym.size());
        end
        n7f  = 0;
        nlit = 0;
        gaps = 0;
        for (int i = 0; i < got_sym.size(); i++) begin
            if (i < 256 && got_sym[i] === 7'h7F) n7f++;
            if (i >= 256 && got_sym[i] === 7'(i - 255)) nlit++;
            if (got_cyc[i] != got_cyc[0] + i) gaps++;
        end
        total++;
        if (n7f != 256) begin
            bad++;
            $display("FAIL maxrun_symbols: got %0d beats of 7f, want 256", n7f);
        end
        total++;
        if (nlit != 16) begin
            bad++;
            $display("FAIL maxrun_literals: got %0d in-order literals 01..10, want 16", nlit);
        end
        total++;
        if (gaps != 0) begin
            bad++;
            $display("FAIL maxrun_bubbles: got %0d gapped beats, want 0", gaps);
        end
    endtask

    task automatic test_backpressure();
        logic rdy;
        clear_log();
        drive(1'b1, 8'h85, 1'b1);
        drive(1'b1, 8'h05, 1'b1);
        for (int i = 0; i < 16; i++) begin
            rdy = !(i >= 3 && i <= 5);
            drive(i == 0, 8'h2A, rdy);
            if (!rdy) begin
                total++;
                if (sym_valid !== 1'b1 || sym_out !== 7'h05) begin
                    bad++;
                    $display("FAIL bp_hold%0d: got valid=%b sym=%h, want 1/05", i, sym_valid, sym_out);
                end
            end
        end
        repeat (4) drive(1'b0, 8'h00, 1'b1);
        total++;
        if (got_sym.size() != 7) begin
            bad++;
            $display("FAIL bp_count: got %0d beats, want 7", got_sym.size());
        end
        for (int i = 0; i < got_sym.size(); i++) begin
            total++;
            if (got_sym[i] !== (i < 6 ? 7'h05 : 7'h2A)) begin
                bad++;
                $display("FAIL bp_beat%0d: got %h, want %h", i, got_sym[i], (i < 6 ? 7'h05 : 7'h2A));
            end
        end
    endtask

    task automatic test_split_header();
        clear_log();
        drive(1'b1, 8'h81, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            total++;
            if (sym_valid !== 1'b0) begin
                bad++;
                $display("FAIL split_wait%0d: got valid=%b, want 0", i, sym_valid);
            end
        end
        drive(1'b1, 8'h02, 1'b1);
        repeat (8) drive(1'b0, 8'h00, 1'b1);
        total++;
        if (got_sym.size() != 3 || got_sym[0] !== 7'h01 || got_sym[2] !== 7'h01) begin
            bad++;
            $display("FAIL split_run: got %0d beats, want 3 beats of 01", got_sym.size());
        end
    endtask

    task automatic test_edge_tokens();
        int n03;
        clear_log();
        drive(1'b1, 8'h00, 1'b1);
        drive(1'b1, 8'h83, 1'b1);
        drive(1'b1, 8'h81, 1'b1);
        repeat (140) drive(1'b0, 8'h00, 1'b1);
        total++;
        if (got_sym.size() != 131 || got_sym[0] !== 7'h00) begin
            bad++;
            $display("FAIL zero_and_hdrcount: got %0d beats, want 131 starting with 00", got_sym.size());
        end
        n03 = 0;
        for (int i = 1; i < got_sym.size(); i++) if (got_sym[i] === 7'h03) n03++;
        total++;
        if (n03 != 130) begin
            bad++;
            $display("FAIL hdrcount_run: got %0d beats of 03, want 130", n03);
        end
    endtask

    task automatic test_reset_midrun();
        int start;
        clear_log();
        drive(1'b1, 8'h85, 1'b1);
        drive(1'b1, 8'h0A, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h11 + i), 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        total++;
        if (fifo_level !== 5'd5 || sym_valid !== 1'b1 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: got lvl=%0d valid=%b ovf=%b, want 5/1/1", fifo_level, sym_valid, overflow);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (sym_valid !== 1'b0 || sym_out !== 7'h00 || overflow !== 1'b0 || fifo_level !== 5'd0) begin
            bad++;
            $display("FAIL async_reset: got valid=%b sym=%h ovf=%b lvl=%0d, want 0/00/0/0",
                     sym_valid, sym_out, overflow, fifo_level);
        end
        @(negedge clock);
        reset_n = 1'b1;
        clear_log();
        start = cyc_n;
        drive(1'b1, 8'h44, 1'b1);
        repeat (8) drive(1'b0, 8'h00, 1'b1);
        total++;
        if (got_sym.size() != 1 || got_sym[0] !== 7'h44 || got_cyc[0] != start + 2) begin
            bad++;
            $display("FAIL post_reset_literal: got %0d beats (first cyc=%0d), want one 44 at cyc 2",
                     got_sym.size(), got_cyc.size() > 0 ? got_cyc[0] - start : -1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc_n = 0;
        test_reset();
        test_literals();
        test_short_run();
        test_max_run();
        test_backpressure();
        test_split_header();
        test_edge_tokens();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
